tl_ul_arb_2to1: RTL
===================

TL_UL_ARB_2TO1 -- requirements
Module: tl_ul_arb_2to1

Interface
REQ-001 SHALL have one clock, `clock`; reset is asynchronous and active-high, `reset`.
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, giving the in-flight A requests allowed per master (1..7).
REQ-003 SHALL have port `clock`  in  1  — rising-edge clock.
REQ-004 SHALL have port `reset`  in  1  — asynchronous active-high reset.
REQ-005 SHALL have ports `mN_a_valid` in 1 and `mN_a_ready` out 1, N=0,1 — upstream A handshake.
REQ-006 SHALL have inputs `mN_a_opcode` 3, `mN_a_param` 3, `mN_a_size` 3, `mN_a_source` 2, `mN_a_address` 32, `mN_a_mask` 4 and `mN_a_data` 32 — upstream A payload.
REQ-007 SHALL have ports `mN_d_valid` out 1 and `mN_d_ready` in 1 — upstream D handshake.
REQ-008 SHALL have outputs `mN_d_opcode` 3, `mN_d_size` 3, `mN_d_source` 2, `mN_d_denied` 1, `mN_d_corrupt` 1 and `mN_d_data` 32 — upstream D payload.
REQ-009 SHALL have ports `s_a_valid` out 1 and `s_a_ready` in 1 — downstream A handshake; `s_a_*` payload outputs match the upstream A fields, except `s_a_source` is 3 bits.
REQ-010 SHALL have ports `s_d_valid` in 1 and `s_d_ready` out 1 — downstream D handshake; `s_d_*` payload inputs match the upstream D fields, except `s_d_source` is 3 bits.

Function
REQ-011 SHALL hold one downstream A request in a registered slot; `s_a_*` are driven only from this slot.
- Slot is empty or full.
- Slot loads when it is empty, or when it is full and `s_a_valid && s_a_ready` in the same cycle.
REQ-012 SHALL grant at most one master per cycle, and only when the slot can load.
- A master is eligible when `mN_a_valid=1` and its outstanding count is below MAX_OUTSTANDING.
- `mN_a_ready` is 1 only for the granted master.
REQ-013 SHALL give a latency of exactly 1 cycle from an upstream A fire to `s_a_valid=1` with that payload.
REQ-014 SHALL remap the source to `s_a_source = {N, mN_a_source}` and pass all other A fields through unchanged.
REQ-015 SHALL route D responses by `s_d_source[2]`:
- `m{s_d_source[2]}_d_valid = s_d_valid`, and the other master's `d_valid` is 0.
- `mN_d_source = s_d_source[1:0]`.
- `s_d_ready` equals the selected master's `d_ready`; the D path is combinational.
REQ-016 SHALL keep a 3-bit outstanding counter per master.
- +1 on that master's A fire.
- −1 on a D fire routed to it.
- Unchanged when both happen in the same cycle.
- Never wraps: an A fire at MAX_OUTSTANDING cannot occur, and a D fire at 0 does not decrement.
REQ-017 SHALL assert nothing when neither master is eligible; the slot drains independently.
REQ-018 SHALL let a master whose counter is full block only itself; the other master continues to be granted.

Reset
REQ-019 SHALL, while `reset=1` (asynchronously):
- empty the slot, so `s_a_valid=0`;
- clear both counters to 0;
- set round-robin priority to master 0;
- drive `mN_a_ready=0`, `mN_d_valid=0` and `s_d_ready=0`.
REQ-020 SHALL discard a slot holding a request at mid-operation reset; that request is not replayed.
REQ-021 SHALL drive all `s_a_*` payload outputs to 0 under reset.

Configuration
REQ-022 SHALL support the macro `TL_ARB_ROUND_ROBIN_EN`.
- Defined: when both masters are eligible, grant the master opposite the last granted one; after reset, prefer master 0.
- Undefined: fixed priority, master 0 always wins, and the priority register is not instantiated.

Verification
REQ-023 SHALL pass this scenario: after reset, `m0_a_valid=1` with source=2 and `address=0x8000_0000`, and `s_a_ready=1` → next cycle `s_a_valid=1`, `s_a_source=3'b010`, `s_a_address=0x8000_0000`.
REQ-024 SHALL pass this scenario: both masters valid for 4 cycles with `s_a_ready=1`:
- With `TL_ARB_ROUND_ROBIN_EN`, grants are 0,1,0,1.
- Without it, grants are 0,0,0,0.
REQ-025 SHALL pass this scenario: m1 issues 4 requests with no D responses → `m1_a_ready` stays 0 while m0 is still granted; one D with `s_d_source=3'b1xx` → m1 is granted again the next cycle.
REQ-026 SHALL pass this scenario: `s_d_valid=1` with `s_d_source=3'b101` and `m1_d_ready=0` → `m1_d_valid=1`, `m0_d_valid=0`, `s_d_ready=0`, and the counter is unchanged until `m1_d_ready=1`.
REQ-027 SHALL pass this scenario: an A fire and a D fire for m0 in the same cycle at count 2 → count remains 2.
REQ-028 SHALL pass this scenario: `reset` asserted while the slot is full and `s_a_ready=0` → `s_a_valid=0` immediately; both counters read 0 after deassertion.

Source files
------------

// File: rtl/tl_ul_arb_2to1.sv
`default_nettype none
// ============================================================================
// Module  : tl_ul_arb_2to1
// Brief   : 2:1 TL-UL A-channel arbiter with registered slot and D routing.
//           TL_ARB_ROUND_ROBIN_EN selects round-robin (else fixed m0 priority).
// Revision: 1.0
// ============================================================================
module tl_ul_arb_2to1 #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        m0_a_valid,
    output logic        m0_a_ready,
    input  logic [2:0]  m0_a_opcode,
    input  logic [2:0]  m0_a_param,
    input  logic [2:0]  m0_a_size,
    input  logic [1:0]  m0_a_source,
    input  logic [31:0] m0_a_address,
    input  logic [3:0]  m0_a_mask,
    input  logic [31:0] m0_a_data,
    output logic        m0_d_valid,
    input  logic        m0_d_ready,
    output logic [2:0]  m0_d_opcode,
    output logic [2:0]  m0_d_size,
    output logic [1:0]  m0_d_source,
    output logic        m0_d_denied,
    output logic        m0_d_corrupt,
    output logic [31:0] m0_d_data,
    input  logic        m1_a_valid,
    output logic        m1_a_ready,
    input  logic [2:0]  m1_a_opcode,
    input  logic [2:0]  m1_a_param,
    input  logic [2:0]  m1_a_size,
    input  logic [1:0]  m1_a_source,
    input  logic [31:0] m1_a_address,
    input  logic [3:0]  m1_a_mask,
    input  logic [31:0] m1_a_data,
    output logic        m1_d_valid,
    input  logic        m1_d_ready,
    output logic [2:0]  m1_d_opcode,
    output logic [2:0]  m1_d_size,
    output logic [1:0]  m1_d_source,
    output logic        m1_d_denied,
    output logic        m1_d_corrupt,
    output logic [31:0] m1_d_data,
    output logic        s_a_valid,
    input  logic        s_a_ready,
    output logic [2:0]  s_a_opcode,
    output logic [2:0]  s_a_param,
    output logic [2:0]  s_a_size,
    output logic [2:0]  s_a_source,
    output logic [31:0] s_a_address,
    output logic [3:0]  s_a_mask,
    output logic [31:0] s_a_data,
    input  logic        s_d_valid,
    output logic        s_d_ready,
    input  logic [2:0]  s_d_opcode,
    input  logic [2:0]  s_d_size,
    input  logic [2:0]  s_d_source,
    input  logic        s_d_denied,
    input  logic        s_d_corrupt,
    input  logic [31:0] s_d_data
);

    localparam logic [2:0] c_MAX_OUT = 3'(MAX_OUTSTANDING);

    logic        r_slot_valid;
    logic [2:0]  r_opcode, r_param, r_size, r_source;
    logic [31:0] r_address, r_data;
    logic [3:0]  r_mask;
    logic [2:0]  r_cnt0, r_cnt1;

    logic w_can_load, w_elig0, w_elig1, w_pick1, w_gnt0, w_gnt1;
    logic w_d_fire0, w_d_fire1;

    assign w_can_load = !r_slot_valid || s_a_ready;
    assign w_elig0    = m0_a_valid && (r_cnt0 < c_MAX_OUT);
    assign w_elig1    = m1_a_valid && (r_cnt1 < c_MAX_OUT);

`ifdef TL_ARB_ROUND_ROBIN_EN
    // r_prio names the master that wins a tie next; it flips on every grant.
    logic r_prio;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)       r_prio <= 1'b0;
        else if (w_gnt0) r_prio <= 1'b1;
        else if (w_gnt1) r_prio <= 1'b0;
    end

    assign w_pick1 = w_elig1 && (!w_elig0 || r_prio);
`else
    assign w_pick1 = w_elig1 && !w_elig0;
`endif

    assign w_gnt0 = !reset && w_can_load && w_elig0 && !w_pick1;
    assign w_gnt1 = !reset && w_can_load && w_pick1;

    assign m0_a_ready = w_gnt0;
    assign m1_a_ready = w_gnt1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_slot_valid <= 1'b0;
            r_opcode     <= '0;
            r_param      <= '0;
            r_size       <= '0;
            r_source     <= '0;
            r_address    <= '0;
            r_mask       <= '0;
            r_data       <= '0;
        end else if (w_gnt1) begin
            r_slot_valid <= 1'b1;
            r_opcode     <= m1_a_opcode;
            r_param      <= m1_a_param;
            r_size       <= m1_a_size;
            r_source     <= {1'b1, m1_a_source};
            r_address    <= m1_a_address;
            r_mask       <= m1_a_mask;
            r_data       <= m1_a_data;
        end else if (w_gnt0) begin
            r_slot_valid <= 1'b1;
            r_opcode     <= m0_a_opcode;
            r_param      <= m0_a_param;
            r_size       <= m0_a_size;
            r_source     <= {1'b0, m0_a_source};
            r_address    <= m0_a_address;
            r_mask       <= m0_a_mask;
            r_data       <= m0_a_data;
        end else if (s_a_ready) begin
            r_slot_valid <= 1'b0;
        end
    end

    assign s_a_valid   = r_slot_valid;
    assign s_a_opcode  = r_opcode;
    assign s_a_param   = r_param;
    assign s_a_size    = r_size;
    assign s_a_source  = r_source;
    assign s_a_address = r_address;
    assign s_a_mask    = r_mask;
    assign s_a_data    = r_data;

    // D path is purely combinational, steered by the master bit of the source.
    assign m0_d_valid = !reset && s_d_valid && !s_d_source[2];
    assign m1_d_valid = !reset && s_d_valid &&  s_d_source[2];
    assign s_d_ready  = !reset && (s_d_source[2] ? m1_d_ready : m0_d_ready);

    assign m0_d_opcode  = s_d_opcode;
    assign m0_d_size    = s_d_size;
    assign m0_d_source  = s_d_source[1:0];
    assign m0_d_denied  = s_d_denied;
    assign m0_d_corrupt = s_d_corrupt;
    assign m0_d_data    = s_d_data;
    assign m1_d_opcode  = s_d_opcode;
    assign m1_d_size    = s_d_size;
    assign m1_d_source  = s_d_source[1:0];
    assign m1_d_denied  = s_d_denied;
    assign m1_d_corrupt = s_d_corrupt;
    assign m1_d_data    = s_d_data;

    assign w_d_fire0 = m0_d_valid && s_d_ready;
    assign w_d_fire1 = m1_d_valid && s_d_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cnt0 <= '0;
            r_cnt1 <= '0;
        end else begin
            if (w_gnt0 && !w_d_fire0)                         r_cnt0 <= r_cnt0 + 3'd1;
            else if (w_d_fire0 && !w_gnt0 && r_cnt0 != 3'd0) r_cnt0 <= r_cnt0 - 3'd1;
            if (w_gnt1 && !w_d_fire1)                         r_cnt1 <= r_cnt1 + 3'd1;
            else if (w_d_fire1 && !w_gnt1 && r_cnt1 != 3'd0) r_cnt1 <= r_cnt1 - 3'd1;
        end
    end

endmodule
`default_nettype wire
